branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the pipelined RV32I core. It sits beside the EX-stage branch comparator (brc) and drives the comparator's unsigned-select input from the branch type. It stalls the front end while branch operands are not yet forwardable, and converts the comparator's taken decision into a registered PC redirect plus pipeline flush. It also keeps saturating branch statistics for the performance counters.

## Interface
- FLUSH_CYCLES, 1, number of cycles redirect/flush stay asserted after a taken resolution (1..15)
- CNT_W, 16, width of statistics counters
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_br_valid  in  1  conditional branch or jump present in EX
- i_jump  in  1  EX instruction is JAL/JALR (always taken)
- i_br_type  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6/7 reserved
- i_opnd_ready  in  1  rs1/rs2 resolvable by forwarding this cycle (0 on load-use)
- i_pc_sel  in  1  brc taken result for current EX operands
- i_target  in  32  branch/jump target computed in EX
- i_cnt_clr  in  1  synchronous clear of statistics counters
- o_br_uns  out  1  to brc i_br_uns; 1 iff i_br_type is 4 or 5
- o_stall  out  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM
- o_redirect  out  1  PC mux selects o_redirect_pc
- o_redirect_pc  out  32  registered target
- o_flush_if_id  out  1  squash IF/ID
- o_flush_id_ex  out  1  squash ID/EX
- o_br_total  out  CNT_W  resolved branches/jumps
- o_br_taken  out  CNT_W  taken branches/jumps

## Operation
- States: IDLE, WAIT, FLUSH. Reset state is IDLE. All outputs are reset to 0.
- o_br_uns is combinational from i_br_type in every state.
- IDLE or WAIT, i_br_valid=1, i_opnd_ready=0: o_stall=1 (combinational), next state WAIT.
- IDLE or WAIT, i_br_valid=1, i_opnd_ready=1: this is the resolution cycle. o_stall=0 and o_br_total increments.
  - taken = i_jump | (i_pc_sel & i_br_type<=5).
  - If taken: o_br_taken increments, target is latched, and next state is FLUSH.
  - If not taken: next state is IDLE.
- WAIT with i_br_valid=0 (EX squashed externally): return to IDLE with no count.
- FLUSH: o_redirect=1, o_flush_if_id=1, o_flush_id_ex=1, and o_redirect_pc holds the latched target.
  - A down-counter loaded with FLUSH_CYCLES-1 decrements each cycle; the FSM goes to IDLE after it reaches 0.
  - i_br_valid is ignored in FLUSH because that instruction is wrong-path.
- Reserved br_type 6/7 without i_jump resolves not-taken and is still counted in o_br_total.
- Counters saturate at all-ones. i_cnt_clr has priority over increments in the same cycle.
- o_redirect_pc keeps its last value outside FLUSH and is 0 after reset.

## Timing
- Stall is zero-latency: it follows i_br_valid/i_opnd_ready in the same cycle.
- Redirect latency is 1 cycle. Resolution happens at edge N; o_redirect, the flushes, and o_redirect_pc are valid from N+1 through N+FLUSH_CYCLES.
- Counters update at the resolution edge and are visible the next cycle.
- Back-to-back: a branch arriving in EX in the first cycle after FLUSH exits is resolved normally.
- An asynchronous reset asserted mid-WAIT or mid-FLUSH forces IDLE immediately. All outputs go to 0 and the counters clear.

## Structure
- The shared package holds the br_type enum (BR_EQ..BR_GEU) and the state typedef {IDLE, WAIT, FLUSH}.
- The package also holds the FLUSH_MAX=15 constant.
- Sub-module sat_counter (parameter W, with inc and clr inputs) is instantiated twice for the statistics.

## Test plan
- BEQ, rs1=rs2=10, i_pc_sel=1, i_opnd_ready=1, i_target=0x100 -> next cycle o_redirect=1, o_redirect_pc=0x100, both flushes=1 for exactly 1 cycle; o_br_total=1, o_br_taken=1.
- BNE not taken (i_pc_sel=0) -> no redirect or flush; o_br_total increments, o_br_taken unchanged.
- BLTU with i_opnd_ready=0 for 2 cycles, then 1 with i_pc_sel=1 -> o_stall=1 for 2 cycles, o_br_uns=1 throughout, redirect on the cycle after readiness.
- FLUSH_CYCLES=3, JAL to 0x2000 -> o_redirect held 3 cycles; an i_br_valid pulse during FLUSH is not counted.
- Preload o_br_total=0xFFFF, resolve one more branch -> stays 0xFFFF; assert i_cnt_clr together with a resolution -> 0.
- Assert i_rst_n=0 during the second FLUSH cycle -> all outputs 0 immediately; after release the FSM is in IDLE with no residual redirect.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution controller.
//   br_type_e : EX-stage branch comparison encoding (6/7 reserved)
//   state_e   : controller FSM states
//   FLUSH_MAX : largest supported redirect/flush hold length
package branch_ctrl_pkg;

  localparam int FLUSH_MAX = 15;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // The comparator must run unsigned only for the two *U compares.
  function automatic logic is_unsigned(input logic [2:0] br_type);
    return (br_type == BR_LTU) || (br_type == BR_GEU);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// EX-stage branch handshake between the pipeline (master) and branch_ctrl (slave).
//   i_br_valid/i_jump/i_br_type/i_opnd_ready/i_pc_sel/i_target : EX branch info
//   o_br_uns      : unsigned select back to the comparator
//   o_stall       : front-end hold
//   o_redirect/o_redirect_pc/o_flush_if_id/o_flush_id_ex : taken-branch recovery
interface branch_ctrl_if;
  logic        i_br_valid;
  logic        i_jump;
  logic [2:0]  i_br_type;
  logic        i_opnd_ready;
  logic        i_pc_sel;
  logic [31:0] i_target;
  logic        o_br_uns;
  logic        o_stall;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush_if_id;
  logic        o_flush_id_ex;

  modport slave (
    input  i_br_valid, i_jump, i_br_type, i_opnd_ready, i_pc_sel, i_target,
    output o_br_uns, o_stall, o_redirect, o_redirect_pc, o_flush_if_id, o_flush_id_ex
  );

  modport master (
    output i_br_valid, i_jump, i_br_type, i_opnd_ready, i_pc_sel, i_target,
    input  o_br_uns, o_stall, o_redirect, o_redirect_pc, o_flush_if_id, o_flush_id_ex
  );
endinterface

// File: rtl/branch_ctrl_sat_counter.sv
// Saturating up-counter for branch statistics.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : count one event
//   i_clr          : synchronous clear, wins over i_inc
//   o_cnt          : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller beside the EX-stage comparator.
// Stalls while operands are not forwardable, turns a taken resolution into a
// registered redirect + flush held for FLUSH_CYCLES cycles, and counts branches.
//   i_clk, i_rst_n : clock, async active-low reset
//   br             : EX branch handshake (slave side)
//   i_cnt_clr      : synchronous clear of statistics
//   o_br_total     : resolved branches/jumps (saturating)
//   o_br_taken     : taken branches/jumps (saturating)
//
// state | meaning
// IDLE  | no branch pending in EX
// WAIT  | branch in EX stalled on operand forwarding
// FLUSH | redirect/flush asserted, EX contents are wrong-path
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  branch_ctrl_if.slave     br,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_br_total,
  output logic [CNT_W-1:0] o_br_taken
);

  localparam int TW = $clog2(FLUSH_MAX + 1);

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic          r_redirect;
  logic [31:0]   r_redirect_pc;

  logic w_active;
  logic w_resolve;
  logic w_taken;

  // A valid branch in FLUSH is wrong-path and must not stall or resolve.
  assign w_active  = (r_state != FLUSH) && br.i_br_valid;
  assign w_resolve = w_active && br.i_opnd_ready;
  // Reserved types (6/7) only redirect when they are jumps.
  assign w_taken   = br.i_jump || (br.i_pc_sel && (br.i_br_type <= 3'd5));

  assign br.o_br_uns      = is_unsigned(br.i_br_type);
  assign br.o_stall       = w_active && !br.i_opnd_ready;
  assign br.o_redirect    = r_redirect;
  assign br.o_flush_if_id = r_redirect;
  assign br.o_flush_id_ex = r_redirect;
  assign br.o_redirect_pc = r_redirect_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          if (w_resolve && w_taken) begin
            r_state       <= FLUSH;
            r_timer       <= TW'(FLUSH_CYCLES - 1);
            r_redirect    <= 1'b1;
            r_redirect_pc <= br.i_target;
          end else if (w_active && !w_resolve) begin
            r_state <= WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (r_timer == '0) begin
            r_state    <= IDLE;
            r_redirect <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_redirect <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_total (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_resolve),
    .i_clr   (i_cnt_clr),
    .o_cnt   (o_br_total)
  );

  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_resolve && w_taken),
    .i_clr   (i_cnt_clr),
    .o_cnt   (o_br_taken)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: instance A (FLUSH_CYCLES=1) and B (FLUSH_CYCLES=3).
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr_a;
  logic        cnt_clr_b;
  logic [15:0] total_a, taken_a, total_b, taken_b;
  int          n_cmp;
  int          n_err;

  branch_ctrl_if if_a ();
  branch_ctrl_if if_b ();

  branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .br(if_a), .i_cnt_clr(cnt_clr_a),
    .o_br_total(total_a), .o_br_taken(taken_a)
  );

  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .br(if_b), .i_cnt_clr(cnt_clr_b),
    .o_br_total(total_b), .o_br_taken(taken_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic j, input logic [2:0] t,
                         input logic rdy, input logic sel, input logic [31:0] tgt);
    if_a.i_br_valid = v; if_a.i_jump = j; if_a.i_br_type = t;
    if_a.i_opnd_ready = rdy; if_a.i_pc_sel = sel; if_a.i_target = tgt;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic j, input logic [2:0] t,
                         input logic rdy, input logic sel, input logic [31:0] tgt);
    if_b.i_br_valid = v; if_b.i_jump = j; if_b.i_br_type = t;
    if_b.i_opnd_ready = rdy; if_b.i_pc_sel = sel; if_b.i_target = tgt;
    #1;
  endtask

  task automatic chk_flush_a(input string tag, input logic exp);
    chk({tag, "_redir"}, if_a.o_redirect, exp);
    chk({tag, "_fifd"}, if_a.o_flush_if_id, exp);
    chk({tag, "_fidex"}, if_a.o_flush_id_ex, exp);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; cnt_clr_a = 1'b0; cnt_clr_b = 1'b0;
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    drive_b(0, 0, 3'd0, 0, 0, 32'h0);
    #10;
    chk_flush_a("rst", 1'b0);
    chk("rst_pc", if_a.o_redirect_pc, 32'h0);
    chk("rst_stall", if_a.o_stall, 1'b0);
    chk("rst_total", total_a, 16'd0);
    chk("rst_taken", taken_a, 16'd0);
    #2 rst_n = 1'b1;
    step();

    // BEQ taken to 0x100, redirect for exactly one cycle
    drive_a(1, 0, BR_EQ, 1, 1, 32'h100);
    chk("beq_stall", if_a.o_stall, 1'b0);
    chk("beq_uns", if_a.o_br_uns, 1'b0);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk_flush_a("beq_f1", 1'b1);
    chk("beq_pc", if_a.o_redirect_pc, 32'h100);
    chk("beq_total", total_a, 16'd1);
    chk("beq_taken", taken_a, 16'd1);
    step();
    chk_flush_a("beq_f2", 1'b0);
    chk("beq_pc_hold", if_a.o_redirect_pc, 32'h100);

    // BNE not taken
    drive_a(1, 0, BR_NE, 1, 0, 32'h200);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk_flush_a("bne", 1'b0);
    chk("bne_total", total_a, 16'd2);
    chk("bne_taken", taken_a, 16'd1);
    chk("bne_pc", if_a.o_redirect_pc, 32'h100);

    // BLTU stalled two cycles, then taken
    drive_a(1, 0, BR_LTU, 0, 0, 32'h300);
    chk("bltu_stall0", if_a.o_stall, 1'b1);
    chk("bltu_uns0", if_a.o_br_uns, 1'b1);
    step();
    chk("bltu_stall1", if_a.o_stall, 1'b1);
    chk("bltu_uns1", if_a.o_br_uns, 1'b1);
    chk("bltu_redir1", if_a.o_redirect, 1'b0);
    step();
    drive_a(1, 0, BR_LTU, 1, 1, 32'h300);
    chk("bltu_stall2", if_a.o_stall, 1'b0);
    chk("bltu_uns2", if_a.o_br_uns, 1'b1);
    chk("bltu_total_wait", total_a, 16'd2);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk_flush_a("bltu", 1'b1);
    chk("bltu_pc", if_a.o_redirect_pc, 32'h300);
    chk("bltu_total", total_a, 16'd3);
    chk("bltu_taken", taken_a, 16'd2);
    step();
    chk("bltu_redir_end", if_a.o_redirect, 1'b0);

    // Squash in WAIT: no count
    drive_a(1, 0, BR_GE, 0, 1, 32'h0);
    chk("bge_uns", if_a.o_br_uns, 1'b0);
    chk("sq_stall", if_a.o_stall, 1'b1);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk("sq_stall_off", if_a.o_stall, 1'b0);
    step();
    chk("sq_total", total_a, 16'd3);

    // Reserved type 6 with pc_sel=1: counted, not taken
    drive_a(1, 0, 3'd6, 1, 1, 32'h600);
    chk("rsv_uns", if_a.o_br_uns, 1'b0);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk("rsv_redir", if_a.o_redirect, 1'b0);
    chk("rsv_total", total_a, 16'd4);
    chk("rsv_taken", taken_a, 16'd2);

    // Jump, wrong-path branch in FLUSH ignored, then resolved right after exit
    drive_a(1, 1, 3'd7, 1, 0, 32'h400);
    step();
    drive_a(1, 0, BR_EQ, 1, 1, 32'h500);
    chk("jmp_redir", if_a.o_redirect, 1'b1);
    chk("jmp_pc", if_a.o_redirect_pc, 32'h400);
    chk("fl_stall", if_a.o_stall, 1'b0);
    step();
    chk("b2b_gap", if_a.o_redirect, 1'b0);
    chk("b2b_total0", total_a, 16'd5);
    chk("b2b_stall", if_a.o_stall, 1'b0);
    step();
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk("b2b_redir", if_a.o_redirect, 1'b1);
    chk("b2b_pc", if_a.o_redirect_pc, 32'h500);
    chk("b2b_total", total_a, 16'd6);
    chk("b2b_taken", taken_a, 16'd4);
    step();

    // Clear, fill to saturation, then clear together with a resolution
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    chk("clr_total", total_a, 16'd0);
    chk("clr_taken", taken_a, 16'd0);
    drive_a(1, 0, BR_EQ, 1, 0, 32'h0);
    repeat (65535) step();
    chk("sat_fill", total_a, 16'hFFFF);
    step();
    chk("sat_hold", total_a, 16'hFFFF);
    chk("sat_taken", taken_a, 16'd0);
    drive_a(1, 0, BR_EQ, 1, 1, 32'h700);
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    drive_a(0, 0, 3'd0, 0, 0, 32'h0);
    chk("clrres_total", total_a, 16'd0);
    chk("clrres_taken", taken_a, 16'd0);
    chk("clrres_redir", if_a.o_redirect, 1'b1);
    step();

    // Instance B: JAL to 0x2000 held three cycles, pulse during FLUSH ignored
    drive_b(1, 1, BR_EQ, 1, 0, 32'h2000);
    step();
    drive_b(1, 0, BR_EQ, 1, 1, 32'h2100);
    chk("jal_r1", if_b.o_redirect, 1'b1);
    chk("jal_pc", if_b.o_redirect_pc, 32'h2000);
    step();
    drive_b(0, 0, 3'd0, 0, 0, 32'h0);
    chk("jal_r2", if_b.o_redirect, 1'b1);
    step();
    chk("jal_r3", if_b.o_redirect, 1'b1);
    chk("jal_fidex3", if_b.o_flush_id_ex, 1'b1);
    step();
    chk("jal_r4", if_b.o_redirect, 1'b0);
    chk("jal_total", total_b, 16'd1);
    chk("jal_taken", taken_b, 16'd1);

    // Async reset in second FLUSH cycle
    drive_b(1, 1, BR_EQ, 1, 0, 32'h3000);
    step();
    drive_b(0, 0, 3'd0, 0, 0, 32'h0);
    chk("rf_total", total_b, 16'd2);
    step();
    chk("rf_r2", if_b.o_redirect, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_redir", if_b.o_redirect, 1'b0);
    chk("ar_fifd", if_b.o_flush_if_id, 1'b0);
    chk("ar_fidex", if_b.o_flush_id_ex, 1'b0);
    chk("ar_pc", if_b.o_redirect_pc, 32'h0);
    chk("ar_total", total_b, 16'd0);
    chk("ar_taken", taken_b, 16'd0);
    chk("ar_total_a", total_a, 16'd0);
    #3 rst_n = 1'b1;
    step();
    chk("post_redir", if_b.o_redirect, 1'b0);
    step();
    chk("post_redir2", if_b.o_redirect, 1'b0);
    drive_b(1, 0, BR_GEU, 1, 0, 32'h0);
    chk("post_uns", if_b.o_br_uns, 1'b1);
    step();
    drive_b(0, 0, 3'd0, 0, 0, 32'h0);
    chk("post_total", total_b, 16'd1);
    chk("post_redir3", if_b.o_redirect, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
